// File: rtl/seg_pattern_decoder.sv
// Active-low seven-segment bus back to hex digit, with stability filter,
// change-only reporting and a one-entry valid/ready result buffer.
module seg_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic [7:0] err_count,
  output logic       overflow
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK  = 7'h7F;

  logic [6:0] sample_q;
  logic [7:0] run;
  logic [6:0] last_pat;
  logic       last_vld;

  logic       legal;
  logic [3:0] dec;
  logic       stable;
  logic       blank;
  logic       event_v;
  logic       can_load;

  always_comb begin
    legal = 1'b1;
    dec   = 4'h0;
    case (sample_q)
      7'h40: dec = 4'h0;
      7'h79: dec = 4'h1;
      7'h24: dec = 4'h2;
      7'h30: dec = 4'h3;
      7'h19: dec = 4'h4;
      7'h12: dec = 4'h5;
      7'h02: dec = 4'h6;
      7'h78: dec = 4'h7;
      7'h00: dec = 4'h8;
      7'h10: dec = 4'h9;
      7'h08: dec = 4'hA;
      7'h03: dec = 4'hB;
      7'h46: dec = 4'hC;
      7'h21: dec = 4'hD;
      7'h06: dec = 4'hE;
      7'h0E: dec = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  assign stable   = (run == STABLE);
  assign blank    = (sample_q == BLANK);
  // only report a pattern when it differs from the last one reported
  assign event_v  = stable && !blank &&
                    (!last_vld || (sample_q != last_pat));
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q  <= BLANK;
      run       <= 8'd0;
      last_pat  <= 7'd0;
      last_vld  <= 1'b0;
      out_valid <= 1'b0;
      out_digit <= 4'd0;
      out_err   <= 1'b0;
      err_count <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      sample_q <= seg_in;
      if (seg_in != sample_q)
        run <= 8'd1;
      else if (run != 8'hFF)
        run <= run + 8'd1;

      if (stable) begin
        if (blank) begin
          last_vld <= 1'b0;
        end else begin
          last_pat <= sample_q;
          last_vld <= 1'b1;
        end
      end

      if (event_v && can_load) begin
        out_valid <= 1'b1;
        out_digit <= legal ? dec : 4'd0;
        out_err   <= !legal;
      end else begin
        if (event_v)
          overflow <= 1'b1;
        if (out_valid && out_ready)
          out_valid <= 1'b0;
      end

      // counted whether the illegal event is loaded or dropped
      if (event_v && !legal && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder with an expected-result queue
// compared whenever the DUT presents a buffered result.
module tb_seg_pattern_decoder;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic [7:0] err_count;
  logic       overflow;

  int checks;
  int failures;
  logic [4:0] q[$];
  logic [6:0] pats [16];

  seg_pattern_decoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_digit (out_digit),
    .out_err   (out_err),
    .err_count (err_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    tick(n);
  endtask

  task automatic push(input logic e, input logic [3:0] d);
    q.push_back({e, d});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      tick(1);
    end
    chk(tag, q.size(), 0);
  endtask

  // scoreboard: front entry must be on the bus while valid, popped on accept
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", out_valid, 1'b0);
      end else begin
        chk("sb_digit", out_digit, q[0][3:0]);
        chk("sb_err", out_err, q[0][4]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    pats = '{7'h40, 7'h79, 7'h24, 7'h30,
             7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03,
             7'h46, 7'h21, 7'h06, 7'h0E};
    reset     = 1'b1;
    seg_in    = 7'h7F;
    out_ready = 1'b1;
    tick(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_digit", out_digit, 0);
    chk("rst_err", out_err, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_ovf", overflow, 0);

    // basic decode and latency
    reset  = 1'b0;
    seg_in = 7'h30;
    push(1'b0, 4'h3);
    tick(4);
    chk("lat_before", out_valid, 0);
    tick(1);
    chk("lat_valid", out_valid, 1);
    chk("lat_digit", out_digit, 4'h3);
    tick(1);
    chk("lat_drop", out_valid, 0);
    tick(10);
    chk("held_quiet", out_valid, 0);
    drain("basic_drain");

    // full sweep then one illegal
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 4'(i));
      hold(pats[i], 6);
    end
    push(1'b1, 4'h0);
    hold(7'h55, 6);
    chk("sweep_errcnt", err_count, 1);
    drain("sweep_drain");

    // glitch, then blank re-report
    push(1'b0, 4'h0);
    hold(7'h40, 6);
    hold(7'h79, 2);
    hold(7'h40, 8);
    hold(7'h7F, 5);
    push(1'b0, 4'h0);
    hold(7'h40, 6);
    drain("glitch_drain");

    // backpressure and overflow
    out_ready = 1'b0;
    push(1'b0, 4'h2);
    hold(7'h24, 6);
    hold(7'h19, 6);
    chk("bp_valid", out_valid, 1);
    chk("bp_digit", out_digit, 4'h2);
    chk("bp_ovf", overflow, 1);
    out_ready = 1'b1;
    tick(1);
    chk("bp_drained", out_valid, 0);
    drain("bp_drain");

    // pop and push in the same cycle
    out_ready = 1'b0;
    push(1'b0, 4'h5);
    hold(7'h12, 6);
    seg_in = 7'h02;
    tick(4);
    out_ready = 1'b1;
    push(1'b0, 4'h6);
    tick(1);
    out_ready = 1'b0;
    chk("pp_valid", out_valid, 1);
    chk("pp_digit", out_digit, 4'h6);
    out_ready = 1'b1;
    tick(2);
    chk("pp_empty", out_valid, 0);
    drain("pp_drain");

    // err_count saturation
    for (int i = 0; i < 300; i++) begin
      push(1'b1, 4'h0);
      hold((i % 2) != 0 ? 7'h2A : 7'h55, 4);
    end
    hold(7'h7F, 6);
    chk("sat_errcnt", err_count, 8'hFF);
    drain("sat_drain");

    // reset mid-operation
    out_ready = 1'b0;
    push(1'b0, 4'h7);
    hold(7'h78, 6);
    chk("mid_valid", out_valid, 1);
    hold(7'h00, 2);
    reset = 1'b1;
    q.delete();
    tick(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_digit", out_digit, 0);
    chk("mid_rst_errcnt", err_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    push(1'b0, 4'h8);
    tick(4);
    chk("rel_before", out_valid, 0);
    tick(1);
    chk("rel_valid", out_valid, 1);
    chk("rel_digit", out_digit, 4'h8);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
